// File: rtl/myipll_pkg.sv
// Shared constants, types and helpers for the myipll S00_AXI register file.
package myipll_pkg;

  localparam int NUM_REGS  = 4;
  localparam int REG_IDX_W = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [3:0] REG0_OFF = 4'h0;
  localparam logic [3:0] REG1_OFF = 4'h4;
  localparam logic [3:0] REG2_OFF = 4'h8;
  localparam logic [3:0] REG3_OFF = 4'hC;

  // Byte offset to register index; the low two address bits never select a register.
  function automatic reg_idx_t addr_to_idx(input logic [3:0] addr);
    return addr[3:2];
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] result;
    result = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) result[8*i +: 8] = new_val[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/myipll_axil_hold.sv
// One-entry valid/ready holding register: accepts a beat while empty and
// keeps it until the consumer clears it.
module myipll_axil_hold #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         clear,
  output logic         full,
  output logic [W-1:0] data
);

  assign in_ready = !full;

  // Capture and clear never coincide: capture needs the slot empty, clear needs it full.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      data <= in_data;
    end
  end

endmodule

// File: rtl/myipll_s00_axi_regs.sv
// AXI4-Lite slave with four 32-bit registers and per-register write pulses.
// Define MYIPLL_WSTRB_EN to make writes honour WSTRB byte lanes.
module myipll_s00_axi_regs
  import myipll_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                      AWPROT,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                      ARPROT,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [31:0]                     slv_reg0,
  output logic [31:0]                     slv_reg1,
  output logic [31:0]                     slv_reg2,
  output logic [31:0]                     slv_reg3,
  output logic [NUM_REGS-1:0]             wr_pulse
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic [31:0] slv_regs [NUM_REGS];

  logic                  aw_full;
  reg_idx_t              aw_idx;
  logic                  w_full;
  logic [31:0]           w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  commit;
  logic [31:0]           next_val;
  logic                  ar_hs;
  logic                  unused;

  myipll_axil_hold #(.W(REG_IDX_W)) u_aw_hold (
    .clk      (ACLK),
    .resetn   (ARESETN),
    .in_valid (AWVALID),
    .in_data  (addr_to_idx(AWADDR[3:0])),
    .in_ready (AWREADY),
    .clear    (commit),
    .full     (aw_full),
    .data     (aw_idx)
  );

  myipll_axil_hold #(.W(C_S_AXI_DATA_WIDTH + STRB_W)) u_w_hold (
    .clk      (ACLK),
    .resetn   (ARESETN),
    .in_valid (WVALID),
    .in_data  ({WSTRB, WDATA}),
    .in_ready (WREADY),
    .clear    (commit),
    .full     (w_full),
    .data     ({w_strb, w_data})
  );

  // A held pair retires whenever the response slot is free or being drained this cycle.
  assign commit = aw_full && w_full && (!BVALID || BREADY);

  always_comb begin
    next_val = w_data;
`ifdef MYIPLL_WSTRB_EN
    next_val = apply_wstrb(slv_regs[aw_idx], w_data, w_strb);
`endif
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) slv_regs[i] <= '0;
      wr_pulse <= '0;
      BVALID   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_pulse[i] <= commit && (aw_idx == reg_idx_t'(i));
      end
      if (commit) begin
        slv_regs[aw_idx] <= next_val;
        BVALID           <= 1'b1;
      end else if (BREADY) begin
        BVALID <= 1'b0;
      end
    end
  end

  assign BRESP   = RESP_OKAY;
  assign RRESP   = RESP_OKAY;
  assign ARREADY = !RVALID || RREADY;
  assign ar_hs   = ARVALID && ARREADY;

  // Reads sample the array before any same-edge commit lands, so they see the old value.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
    end else if (ar_hs) begin
      RVALID <= 1'b1;
      RDATA  <= slv_regs[addr_to_idx(ARADDR[3:0])];
    end else if (RREADY) begin
      RVALID <= 1'b0;
    end
  end

  assign slv_reg0 = slv_regs[0];
  assign slv_reg1 = slv_regs[1];
  assign slv_reg2 = slv_regs[2];
  assign slv_reg3 = slv_regs[3];

  assign unused = ^{AWADDR, ARADDR, AWPROT, ARPROT, w_strb};

endmodule
